// File: rtl/rr_select_gen_pkg.sv
// rr_select_gen_pkg
// Shared types and constants for the round-robin select generator.
//   state_t            : arbiter FSM states (IDLE, GNT_A, GNT_B)
//   SIDE_A / SIDE_B    : requester identifiers, identical to the mux select encoding
//   DEFAULT_MAX_GRANT  : default maximum grant length while the other side waits
//   DEFAULT_CNT_W      : default grant counter width
package rr_select_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  // The side identifiers double as the select value driven to the mux.
  localparam logic SIDE_A = 1'b0;
  localparam logic SIDE_B = 1'b1;

  localparam int DEFAULT_MAX_GRANT = 4;
  localparam int DEFAULT_CNT_W     = 8;

endpackage

// File: rtl/rr_select_gen_if.sv
// rr_select_gen_if
// Request/grant bundle between the two requesters and the select generator.
//   req_a, req_b       : requests for the shared mux path
//   select             : mux select (0 = input a, 1 = input b)
//   grant_a, grant_b   : ownership of the path, one-hot or both 0
//   busy               : grant_a | grant_b
//   switch_cnt         : direct A<->B transition count, only when
//                        RR_SELECT_GEN_STATS_EN is defined
// Modports: master = requester side, slave = arbiter side.
interface rr_select_gen_if;

  logic req_a;
  logic req_b;
  logic select;
  logic grant_a;
  logic grant_b;
  logic busy;
`ifdef RR_SELECT_GEN_STATS_EN
  logic [15:0] switch_cnt;
`endif

`ifdef RR_SELECT_GEN_STATS_EN
  modport master (output req_a, output req_b,
                  input select, input grant_a, input grant_b, input busy,
                  input switch_cnt);
  modport slave  (input req_a, input req_b,
                  output select, output grant_a, output grant_b, output busy,
                  output switch_cnt);
`else
  modport master (output req_a, output req_b,
                  input select, input grant_a, input grant_b, input busy);
  modport slave  (input req_a, input req_b,
                  output select, output grant_a, output grant_b, output busy);
`endif

endinterface

// File: rtl/rr_select_gen_grant_timer.sv
// grant_timer
// Saturating grant-length counter for the round-robin select generator.
//   clk, rst_n : clock and asynchronous active-low reset (count clears to 0)
//   load       : start of a new grant, count becomes 1
//   inc        : grant continues, count increments and saturates at MAX_GRANT
//   at_max     : count has reached MAX_GRANT
module grant_timer #(
  parameter int MAX_GRANT = 4,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic inc,
  output logic at_max
);

  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_GRANT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] count;

  // Load wins over increment so a new grant always starts counting at 1,
  // even on a direct handoff where the previous grant was still running.
  // Holding at MAX_VAL keeps at_max asserted for an unchallenged grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= ONE;
    end else if (inc && (count != MAX_VAL)) begin
      count <= count + ONE;
    end
  end

  assign at_max = (count == MAX_VAL);

endmodule

// File: rtl/rr_select_gen.sv
// rr_select_gen
// Registered round-robin select generator for a 2:1 mux. Grants one of two
// requesters at a time, holds select stable for the whole grant and preempts
// a grant after MAX_GRANT cycles when the other side is waiting.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : rr_select_gen_if.slave (req_a/req_b in; select, grant_a,
//                grant_b, busy and optionally switch_cnt out)
// Optional feature: define RR_SELECT_GEN_STATS_EN to add the 16-bit wrapping
// switch_cnt output counting direct GNT_A<->GNT_B transitions.
module rr_select_gen
  import rr_select_gen_pkg::*;
#(
  parameter int MAX_GRANT = DEFAULT_MAX_GRANT,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_select_gen_if.slave  bus
);

  state_t state;
  state_t next_state;
  logic   last;
  logic   at_max;
  logic   load;
  logic   inc;
  logic   select_q;
  logic   grant_a_q;
  logic   grant_b_q;
  logic   busy_q;

  grant_timer #(
    .MAX_GRANT (MAX_GRANT),
    .CNT_W     (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .inc    (inc),
    .at_max (at_max)
  );

  // Next-state logic. A tie from IDLE goes to the side that did not own the
  // path last. A running grant ends when its requester drops, or when it has
  // run MAX_GRANT cycles and the other side is waiting.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    inc        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_a && bus.req_b) begin
          next_state = (last == SIDE_A) ? GNT_B : GNT_A;
        end else if (bus.req_a) begin
          next_state = GNT_A;
        end else if (bus.req_b) begin
          next_state = GNT_B;
        end
      end
      GNT_A: begin
        if (!bus.req_a) begin
          next_state = bus.req_b ? GNT_B : IDLE;
        end else if (at_max && bus.req_b) begin
          next_state = GNT_B;
        end
      end
      GNT_B: begin
        if (!bus.req_b) begin
          next_state = bus.req_a ? GNT_A : IDLE;
        end else if (at_max && bus.req_a) begin
          next_state = GNT_A;
        end
      end
      default: next_state = IDLE;
    endcase
    // Entering a grant state restarts the timer; staying in one advances it.
    load = (next_state != IDLE) && (next_state != state);
    inc  = (next_state != IDLE) && (next_state == state);
  end

  // State, last owner and output registers all follow next_state on the same
  // edge, so select and the grants can never disagree. In IDLE, select and
  // last keep whatever side owned the path most recently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= SIDE_B;
      select_q  <= SIDE_A;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= next_state;
      grant_a_q <= (next_state == GNT_A);
      grant_b_q <= (next_state == GNT_B);
      busy_q    <= (next_state != IDLE);
      if (next_state == GNT_A) begin
        last     <= SIDE_A;
        select_q <= SIDE_A;
      end else if (next_state == GNT_B) begin
        last     <= SIDE_B;
        select_q <= SIDE_B;
      end
    end
  end

  assign bus.select  = select_q;
  assign bus.grant_a = grant_a_q;
  assign bus.grant_b = grant_b_q;
  assign bus.busy    = busy_q;

`ifdef RR_SELECT_GEN_STATS_EN
  logic [15:0] switch_cnt_q;
  logic        is_switch;

  // Only direct owner changes count; a pass through IDLE is not a switch.
  assign is_switch = ((state == GNT_A) && (next_state == GNT_B)) ||
                     ((state == GNT_B) && (next_state == GNT_A));

  // Free-running statistics counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      switch_cnt_q <= '0;
    end else if (is_switch) begin
      switch_cnt_q <= switch_cnt_q + 16'd1;
    end
  end

  assign bus.switch_cnt = switch_cnt_q;
`endif

endmodule

// File: tb/tb_rr_select_gen.sv
// tb_rr_select_gen
// Directed testbench for rr_select_gen with MAX_GRANT=4. Expected outputs are
// hand-computed per step. With RR_SELECT_GEN_STATS_EN defined a second
// instance with MAX_GRANT=1 exercises the switch counter and its wrap.
module tb_rr_select_gen;
  import rr_select_gen_pkg::*;

  localparam int MAXG = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  rr_select_gen_if bus ();

  rr_select_gen #(
    .MAX_GRANT (MAXG),
    .CNT_W     (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

`ifdef RR_SELECT_GEN_STATS_EN
  rr_select_gen_if bus2 ();

  rr_select_gen #(
    .MAX_GRANT (1),
    .CNT_W     (8)
  ) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );
`endif

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic a, input logic b);
    bus.req_a = a;
    bus.req_b = b;
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic exp_ga,
                             input logic exp_gb, input logic exp_sel);
    logic [3:0] obs;
    logic [3:0] exp;
    obs = {bus.select, bus.grant_a, bus.grant_b, bus.busy};
    exp = {exp_sel, exp_ga, exp_gb, exp_ga | exp_gb};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed {sel,ga,gb,busy}=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0);
`ifdef RR_SELECT_GEN_STATS_EN
    bus2.req_a = 1'b0;
    bus2.req_b = 1'b0;
`endif
    step();
    step();
    checkOutput("reset", 1'b0, 1'b0, SIDE_A);
    rst_n = 1'b1;

    // Single requester A, release to IDLE, then B and release: select holds.
    applyStimulus(1'b1, 1'b0);
    step();
    checkOutput("a_grant", 1'b1, 1'b0, SIDE_A);
    applyStimulus(1'b0, 1'b0);
    step();
    checkOutput("a_release", 1'b0, 1'b0, SIDE_A);
    applyStimulus(1'b0, 1'b1);
    step();
    checkOutput("b_grant", 1'b0, 1'b1, SIDE_B);
    applyStimulus(1'b0, 1'b0);
    step();
    checkOutput("b_release_hold", 1'b0, 1'b0, SIDE_B);

    // Both requesting from reset: A x4, B x4, A x4.
    doReset();
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      logic side_b;
      step();
      side_b = ((i / MAXG) % 2) == 1;
      checkOutput($sformatf("preempt%0d", i), !side_b, side_b, side_b);
    end

    // Direct handoff A->B; B's counter restarts so it lasts 4 cycles.
    doReset();
    applyStimulus(1'b1, 1'b0);
    step();
    step();
    applyStimulus(1'b0, 1'b1);
    step();
    checkOutput("handoff", 1'b0, 1'b1, SIDE_B);
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("handoff_hold%0d", i), 1'b0, 1'b1, SIDE_B);
    end
    step();
    checkOutput("handoff_preempt", 1'b1, 1'b0, SIDE_A);

    // A alone for 20 cycles, then B arrives: saturated counter preempts at once.
    doReset();
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      checkOutput($sformatf("hold%0d", i), 1'b1, 1'b0, SIDE_A);
    end
    applyStimulus(1'b1, 1'b1);
    step();
    checkOutput("sat_preempt", 1'b0, 1'b1, SIDE_B);

    // Asynchronous reset in the middle of GNT_B, then A wins the tie.
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst", 1'b0, 1'b0, SIDE_A);
    #2;
    rst_n = 1'b1;
    step();
    checkOutput("post_rst", 1'b1, 1'b0, SIDE_A);

`ifdef RR_SELECT_GEN_STATS_EN
    // Three full A/B rounds give five direct switches.
    doReset();
    applyStimulus(1'b1, 1'b1);
    repeat (6 * MAXG) step();
    checks++;
    assert (bus.switch_cnt === 16'd5) else begin
      errors++;
      $error("[TB] FAIL switch_cnt_rounds: observed=%0d expected=5", bus.switch_cnt);
    end

    // MAX_GRANT=1: after the first grant, every edge is a switch.
    doReset();
    bus2.req_a = 1'b1;
    bus2.req_b = 1'b1;
    repeat (65536) step();
    checks++;
    assert (bus2.switch_cnt === 16'hFFFF) else begin
      errors++;
      $error("[TB] FAIL switch_cnt_full: observed=%h expected=ffff", bus2.switch_cnt);
    end
    step();
    checks++;
    assert (bus2.switch_cnt === 16'h0000) else begin
      errors++;
      $error("[TB] FAIL switch_cnt_wrap: observed=%h expected=0000", bus2.switch_cnt);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
